// File: rtl/rs232_pkg.sv
// Shared types and default constants for the RS-232 RTS/CTS flow-control
// block and its CTS synchronizer.
package rs232_pkg;

   localparam int TIMEOUT_CYCLES_DEF = 1024;
   localparam int LEVEL_W_DEF        = 5;
   localparam int HI_WM_DEF          = 12;
   localparam int LO_WM_DEF          = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_CTS = 2'd1,
      START    = 2'd2,
      BUSY     = 2'd3
   } state_t;

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer bringing the asynchronous CTS line into the clk
// domain; both flops clear on reset so CTS reads as "not clear" at first.
module rs232_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rs232_flow_ctrl.sv
// RTS/CTS flow control in front of a UART transmitter: gates byte launch on
// CTS with a drop-on-timeout, and drives RTS from RX FIFO level hysteresis.
module rs232_flow_ctrl
   import rs232_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int LEVEL_W        = LEVEL_W_DEF,
   parameter int HI_WM          = HI_WM_DEF,
   parameter int LO_WM          = LO_WM_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flow_en,
   input  logic               tx_valid,
   input  logic [7:0]         tx_data,
   output logic               tx_ready,
   output logic               uart_start,
   output logic [7:0]         uart_data,
   input  logic               uart_done,
   input  logic               cts,
   input  logic [LEVEL_W-1:0] rx_level,
   output logic               rts,
   output logic               timeout_err
);

   localparam int CNT_W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] HI_LVL = LEVEL_W'(HI_WM);
   localparam logic [LEVEL_W-1:0] LO_LVL = LEVEL_W'(LO_WM);

   generate
      if (LO_WM >= HI_WM) begin : g_wm_check
         $error("rs232_flow_ctrl: LO_WM must be below HI_WM");
      end
   endgenerate

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       data_q;
   logic             rts_q;
   logic             cts_s;
   logic             load;
   logic             start_c;
   logic             tmo_c;

   rs232_sync u_cts_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cts),
      .q     (cts_s)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tx_ready = 1'b0;
      load     = 1'b0;
      start_c  = 1'b0;
      tmo_c    = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               load    = 1'b1;
               state_d = WAIT_CTS;
            end
         end
         WAIT_CTS: begin
            if (cts_s || !flow_en) begin
               cnt_d   = '0;
               state_d = START;
            end else if (cnt_q == CNT_LAST) begin
               tmo_c   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         START: begin
            start_c = 1'b1;
            state_d = BUSY;
         end
         BUSY: begin
            if (uart_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are masked while reset is held so a byte caught mid-flight
   // never reaches the transmitter or the error line.
   assign uart_start  = start_c & rst_n;
   assign timeout_err = tmo_c & rst_n;
   assign uart_data   = data_q;
   assign rts         = rts_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         rts_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) data_q <= tx_data;
         if (!flow_en)                rts_q <= 1'b1;
         else if (rx_level >= HI_LVL) rts_q <= 1'b0;
         else if (rx_level <= LO_LVL) rts_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rs232_flow_ctrl.sv
// Directed and randomized checks of rs232_flow_ctrl against a
// transaction-level model of launch latency, timeouts and RTS hysteresis.
module tb_rs232_flow_ctrl;

   localparam int TMO = 16;
   localparam int LW  = 5;
   localparam int HI  = 12;
   localparam int LO  = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          flow_en   = 1'b1;
   logic          tx_valid  = 1'b0;
   logic [7:0]    tx_data   = 8'h00;
   logic          uart_done = 1'b0;
   logic          cts       = 1'b1;
   logic [LW-1:0] rx_level  = '0;
   logic          tx_ready;
   logic          uart_start;
   logic [7:0]    uart_data;
   logic          rts;
   logic          timeout_err;

   int   n_assert   = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   n_starts   = 0;
   int   n_tmo      = 0;
   int   last_start = -1;
   int   last_tmo   = -1;
   logic [7:0] last_data = 8'h00;
   logic rts_exp = 1'b1;

   rs232_flow_ctrl #(
      .TIMEOUT_CYCLES (TMO),
      .LEVEL_W        (LW),
      .HI_WM          (HI),
      .LO_WM          (LO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flow_en     (flow_en),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .uart_start  (uart_start),
      .uart_data   (uart_data),
      .uart_done   (uart_done),
      .cts         (cts),
      .rx_level    (rx_level),
      .rts         (rts),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rts_rule(input logic cur, input logic fe,
                                     input int lvl);
      if (!fe) return 1'b1;
      if (lvl >= HI) return 1'b0;
      if (lvl <= LO) return 1'b1;
      return cur;
   endfunction

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rts_exp <= !rst_n ? 1'b1 : rts_rule(rts_exp, flow_en, int'(rx_level));
   end

   always @(negedge clk) begin
      if (uart_start === 1'b1) begin
         n_starts++;
         last_start = cyc;
         last_data  = uart_data;
      end
      if (timeout_err === 1'b1) begin
         n_tmo++;
         last_tmo = cyc;
      end
      chk("rts_model", 32'(rts), 32'(rts_exp));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [7:0] d, output int acc);
      tx_valid = 1'b1;
      tx_data  = d;
      #1;
      chk("accept_ready", 32'(tx_ready), 32'd1);
      acc = cyc;
      tick();
      tx_valid = 1'b0;
   endtask

   initial begin
      int acc;
      int c;
      int s0;
      int t0;
      int ndly;
      logic [7:0] d;

      repeat (3) tick();
      #1;
      chk("rst_start", 32'(uart_start), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      chk("rst_rts", 32'(rts), 32'd1);
      chk("rst_data", 32'(uart_data), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 32'(tx_ready), 32'd1);
      repeat (3) tick();

      // single byte with CTS steady high
      s0 = n_starts;
      accept(8'hA5, acc);
      #1;
      chk("a_n1_nostart", 32'(uart_start), 32'd0);
      chk("a_n1_ready", 32'(tx_ready), 32'd0);
      tick();
      #1;
      chk("a_start", 32'(uart_start), 32'd1);
      chk("a_data", 32'(uart_data), 32'hA5);
      tick();
      tick();
      #1;
      chk("a_busy_ready", 32'(tx_ready), 32'd0);
      chk("a_busy_data", 32'(uart_data), 32'hA5);
      uart_done = 1'b1;
      #1;
      tick();
      uart_done = 1'b0;
      #1;
      chk("a_done_ready", 32'(tx_ready), 32'd1);
      chk("a_nstart", 32'(n_starts), 32'(s0 + 1));
      chk("a_lat", 32'(last_start - acc), 32'd2);

      // CTS held low: byte dropped on timeout
      cts = 1'b0;
      repeat (3) tick();
      s0 = n_starts;
      t0 = n_tmo;
      accept(8'h3C, acc);
      repeat (TMO + 3) tick();
      #1;
      chk("b_tmo_cnt", 32'(n_tmo), 32'(t0 + 1));
      chk("b_tmo_cyc", 32'(last_tmo - acc), 32'(TMO));
      chk("b_nostart", 32'(n_starts), 32'(s0));
      chk("b_ready", 32'(tx_ready), 32'd1);

      // CTS rises while waiting
      s0 = n_starts;
      t0 = n_tmo;
      accept(8'h11, acc);
      repeat (4) tick();
      cts = 1'b1;
      c = cyc;
      repeat (5) tick();
      #1;
      chk("c_nstart", 32'(n_starts), 32'(s0 + 1));
      chk("c_lat", 32'(last_start - c), 32'd3);
      chk("c_data", 32'(last_data), 32'h11);
      chk("c_notmo", 32'(n_tmo), 32'(t0));
      uart_done = 1'b1;
      tick();
      uart_done = 1'b0;
      #1;
      chk("c_ready", 32'(tx_ready), 32'd1);

      // RX level sweep for RTS hysteresis
      for (int l = 0; l <= 13; l++) begin
         rx_level = LW'(l);
         tick();
         #1;
         chk($sformatf("d_up_%0d", l), 32'(rts), (l >= HI) ? 32'd0 : 32'd1);
      end
      for (int l = 12; l >= 3; l--) begin
         rx_level = LW'(l);
         tick();
         #1;
         chk($sformatf("d_dn_%0d", l), 32'(rts), (l <= LO) ? 32'd1 : 32'd0);
      end
      flow_en = 1'b0;
      for (int l = 0; l <= 26; l++) begin
         rx_level = LW'((l <= 13) ? l : 26 - l);
         tick();
         #1;
         chk($sformatf("d_off_%0d", l), 32'(rts), 32'd1);
      end
      flow_en  = 1'b1;
      rx_level = '0;
      tick();
      tick();

      // reset while BUSY, then a stray uart_done
      rx_level = LW'(13);
      accept(8'h5A, acc);
      repeat (3) tick();
      s0 = n_starts;
      rst_n    = 1'b0;
      rx_level = '0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("e_ready", 32'(tx_ready), 32'd1);
      chk("e_rts", 32'(rts), 32'd1);
      chk("e_data", 32'(uart_data), 32'd0);
      chk("e_start", 32'(uart_start), 32'd0);
      uart_done = 1'b1;
      #1;
      tick();
      uart_done = 1'b0;
      #1;
      chk("e_stray_ready", 32'(tx_ready), 32'd1);
      repeat (3) tick();
      chk("e_nostart", 32'(n_starts), 32'(s0));

      // reset while START, and on the would-be timeout cycle
      s0 = n_starts;
      t0 = n_tmo;
      accept(8'h77, acc);
      tick();
      rst_n = 1'b0;
      #1;
      chk("f_start_gated", 32'(uart_start), 32'd0);
      tick();
      rst_n = 1'b1;
      cts   = 1'b0;
      repeat (3) tick();
      accept(8'h88, acc);
      repeat (TMO - 1) tick();
      rst_n = 1'b0;
      #1;
      chk("f_tmo_gated", 32'(timeout_err), 32'd0);
      tick();
      rst_n = 1'b1;
      cts   = 1'b1;
      repeat (3) tick();
      #1;
      chk("f_nostart", 32'(n_starts), 32'(s0));
      chk("f_notmo", 32'(n_tmo), 32'(t0));
      chk("f_ready", 32'(tx_ready), 32'd1);

      // randomized transactions
      for (int t = 0; t < 30; t++) begin
         flow_en  = 1'($urandom_range(0, 1));
         cts      = flow_en ? 1'b1 : 1'($urandom_range(0, 1));
         rx_level = LW'($urandom_range(0, 31));
         uart_done = 1'($urandom_range(0, 1));
         tick();
         uart_done = 1'b0;
         tick();
         tick();
         #1;
         chk("g_idle_ready", 32'(tx_ready), 32'd1);
         d  = 8'($urandom);
         s0 = n_starts;
         t0 = n_tmo;
         accept(d, acc);
         tx_valid  = 1'($urandom_range(0, 1));
         tx_data   = 8'($urandom);
         uart_done = 1'($urandom_range(0, 1));
         tick();
         tx_valid  = 1'($urandom_range(0, 1));
         uart_done = 1'($urandom_range(0, 1));
         tick();
         uart_done = 1'b0;
         ndly = $urandom_range(0, 4);
         for (int k = 0; k < ndly; k++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            tick();
         end
         #1;
         chk("g_busy_ready", 32'(tx_ready), 32'd0);
         chk("g_hold_data", 32'(uart_data), 32'(d));
         chk("g_nstart", 32'(n_starts), 32'(s0 + 1));
         chk("g_lat", 32'(last_start - acc), 32'd2);
         chk("g_start_data", 32'(last_data), 32'(d));
         chk("g_notmo", 32'(n_tmo), 32'(t0));
         tx_valid  = 1'b0;
         uart_done = 1'b1;
         tick();
         uart_done = 1'b0;
         #1;
         chk("g_done_ready", 32'(tx_ready), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
